// File: rtl/inner_inner_delay_core_if.sv
// Valid/ready stream bundle for one lane endpoint of the delay core.
interface inner_inner_delay_core_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/inner_inner_delay_core.sv
// Dual-lane fixed-latency elastic delay with bubble collapsing.
// Lane A: INPUT_0 -> OUTPUT_1, lane B: INPUT_1 -> OUTPUT_0.
module inner_inner_delay_core #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 3
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  inner_inner_delay_core_if.slave  INPUT_0,
  inner_inner_delay_core_if.slave  INPUT_1,
  inner_inner_delay_core_if.master OUTPUT_0,
  inner_inner_delay_core_if.master OUTPUT_1
);

  logic [DEPTH-1:0] v_q  [2];
  logic [DEPTH-1:0] v_d  [2];
  logic [WIDTH-1:0] d_q  [2][DEPTH];
  logic [WIDTH-1:0] d_d  [2][DEPTH];
  logic [DEPTH-1:0] move [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       in_fire;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] in_data [2];

  // Index 0 is lane A, index 1 is lane B.
  assign in_valid  = {INPUT_1.valid, INPUT_0.valid};
  assign out_ready = {OUTPUT_0.ready, OUTPUT_1.ready};
  assign in_data[0] = INPUT_0.data;
  assign in_data[1] = INPUT_1.data;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      move[l] = '0;
      move[l][DEPTH-1] = v_q[l][DEPTH-1] & out_ready[l];
      for (int k = DEPTH - 2; k >= 0; k--) begin
        move[l][k] = v_q[l][k] & (~v_q[l][k+1] | move[l][k+1]);
      end
      // Ready is held low throughout reset, not just until the first edge.
      in_ready[l] = ASYNCRESETN & (~v_q[l][0] | move[l][0]);
      in_fire[l]  = in_valid[l] & in_ready[l];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int l = 0; l < 2; l++) begin
      if (in_fire[l]) begin
        v_d[l][0] = 1'b1;
        d_d[l][0] = in_data[l];
      end else if (move[l][0]) begin
        v_d[l][0] = 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (move[l][k-1]) begin
          v_d[l][k] = 1'b1;
          d_d[l][k] = d_q[l][k-1];
        end else if (move[l][k]) begin
          v_d[l][k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int l = 0; l < 2; l++) begin
        v_q[l] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          d_q[l][k] <= '0;
        end
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign INPUT_0.ready  = in_ready[0];
  assign INPUT_1.ready  = in_ready[1];
  assign OUTPUT_1.valid = v_q[0][DEPTH-1];
  assign OUTPUT_1.data  = d_q[0][DEPTH-1];
  assign OUTPUT_0.valid = v_q[1][DEPTH-1];
  assign OUTPUT_0.data  = d_q[1][DEPTH-1];

endmodule

// File: tb/tb_inner_inner_delay_core.sv
// Directed bench for inner_inner_delay_core (WIDTH=5, DEPTH=3).
module tb_inner_inner_delay_core;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  always #5 clk_sys = ~clk_sys;

  inner_inner_delay_core_if #(.WIDTH(5)) in0 ();
  inner_inner_delay_core_if #(.WIDTH(5)) in1 ();
  inner_inner_delay_core_if #(.WIDTH(5)) out0 ();
  inner_inner_delay_core_if #(.WIDTH(5)) out1 ();

  inner_inner_delay_core #(.WIDTH(5), .DEPTH(3)) dut (
    .CLK         (clk_sys),
    .ASYNCRESETN (rst_n),
    .INPUT_0     (in0),
    .INPUT_1     (in1),
    .OUTPUT_0    (out0),
    .OUTPUT_1    (out1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  logic [4:0] sb_q[$];
  int         sent;
  int         rcvd;
  logic [4:0] exp_d;

  initial begin
    in0.valid = 1'b1; in0.data = 5'h1f;
    in1.valid = 1'b1; in1.data = 5'h1e;
    out0.ready = 1'b1; out1.ready = 1'b1;

    // Reset held with valids high
    repeat (2) tick();
    #1;
    chk("rst_in0_ready", in0.ready, 0);
    chk("rst_in1_ready", in1.ready, 0);
    chk("rst_out0_valid", out0.valid, 0);
    chk("rst_out1_valid", out1.valid, 0);
    chk("rst_out0_data", out0.data, 0);
    chk("rst_out1_data", out1.data, 0);
    in0.valid = 1'b0; in1.valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in0_ready", in0.ready, 1);
    chk("rel_in1_ready", in1.ready, 1);

    // Latency: accept at end of cycle t, visible in cycle t+3
    tick();
    in0.valid = 1'b1; in0.data = 5'h15;
    #1;
    chk("lat_accept_ready", in0.ready, 1);
    tick();
    in0.valid = 1'b0;
    #1;
    chk("lat_t1_valid", out1.valid, 0);
    tick();
    chk("lat_t2_valid", out1.valid, 0);
    tick();
    chk("lat_t3_valid", out1.valid, 1);
    chk("lat_t3_data", out1.data, 5'h15);
    chk("lat_cross_out0", out0.valid, 0);
    tick();
    chk("lat_consumed", out1.valid, 0);

    // Streaming on lane B: item i accepted end of cycle i, shown in cycle i+3
    for (int c = 0; c < 9; c++) begin
      in1.valid = (c < 5);
      in1.data  = 5'(c + 1);
      #1;
      if (c < 5) chk($sformatf("str_ready_%0d", c), in1.ready, 1);
      chk($sformatf("str_valid_%0d", c), out0.valid, (c >= 3 && c <= 7) ? 1 : 0);
      if (c >= 3 && c <= 7) chk($sformatf("str_data_%0d", c), out0.data, c - 2);
      chk($sformatf("str_lane_a_%0d", c), out1.valid, 0);
      tick();
    end
    in1.valid = 1'b0;

    // Backpressure on lane A
    out1.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in0.valid = 1'b1; in0.data = 5'(10 + i);
      #1;
      chk($sformatf("bp_accept_%0d", i), in0.ready, 1);
      tick();
    end
    in0.data = 5'd13;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_full_ready_%0d", i), in0.ready, 0);
      chk($sformatf("bp_hold_valid_%0d", i), out1.valid, 1);
      chk($sformatf("bp_hold_data_%0d", i), out1.data, 10);
      tick();
    end
    out1.ready = 1'b1;
    #1;
    chk("bp_same_cycle_ready", in0.ready, 1);
    chk("bp_head_data", out1.data, 10);
    tick();
    in0.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_drain_valid_%0d", i), out1.valid, 1);
      chk($sformatf("bp_drain_data_%0d", i), out1.data, 11 + i);
      tick();
    end
    chk("bp_empty", out1.valid, 0);

    // Bubbles: sparse input, toggling output ready
    sent = 0; rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 4; c++) begin
      if (!in0.valid && sent < 4 && c[0] == 1'b0) begin
        in0.valid = 1'b1;
        in0.data  = 5'(20 + sent);
      end
      out1.ready = c[1] ^ c[0];
      #1;
      if (out1.valid && out1.ready) begin
        if (sb_q.size() == 0) begin
          chk("bub_unexpected", out1.data, 0);
        end else begin
          exp_d = sb_q.pop_front();
          chk($sformatf("bub_data_%0d", rcvd), out1.data, exp_d);
        end
        rcvd++;
      end
      if (in0.valid && in0.ready) begin
        sb_q.push_back(in0.data);
        sent++;
        tick();
        in0.valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("bub_received", rcvd, 4);
    chk("bub_sent", sent, 4);
    out1.ready = 1'b1;
    #1;
    chk("bub_no_dup", out1.valid, 0);

    // Mid-flight reset with two items per lane
    out0.ready = 1'b0; out1.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in0.valid = 1'b1; in0.data = 5'(4 + i);
      in1.valid = 1'b1; in1.data = 5'(8 + i);
      tick();
    end
    in0.valid = 1'b0; in1.valid = 1'b0;
    tick();
    #1;
    chk("mr_pre_out1_valid", out1.valid, 1);
    chk("mr_pre_out0_valid", out0.valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out1_valid", out1.valid, 0);
    chk("mr_out0_valid", out0.valid, 0);
    chk("mr_out1_data", out1.data, 0);
    chk("mr_in0_ready", in0.ready, 0);
    tick();
    rst_n = 1'b1;
    out0.ready = 1'b1; out1.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("mr_after_%0d", i), {out1.valid, out0.valid}, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
